if_fetch_stage: RTL and testbench
=================================

Name: if_fetch_stage

Overview:
- Instruction-fetch stage that consumes the next-PC value from new_pc.
- Owns the architectural PC register and a single-outstanding instruction-memory request/response handshake.
- Loads the IF/ID pipeline register (pc, instr, valid) and holds one skid entry so that decode stalls never lose a fetched word.
- Honours branch redirects: redirect wins over stall, and any in-flight fetch is killed.

Parameters:
XLEN, 64, PC and address width
ILEN, 32, instruction width
RESET_PC, 64'd0, PC value loaded on reset
PC_STEP, 4, sequential increment in bytes
NOP_INSTR, 32'h00000013, instruction presented when IF/ID is a bubble

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
redirect_valid  in  1  branch taken (Branch & Zero), from EX
redirect_pc  in  XLEN  target from new_pc
stall  in  1  hazard unit: IF/ID must hold
imem_req  out  1  fetch request
imem_addr  out  XLEN  fetch address
imem_valid  in  1  response valid; completes the request
imem_rdata  in  ILEN  fetched instruction
if_id_valid  out  1  IF/ID holds a real instruction
if_id_pc  out  XLEN  PC of IF/ID instruction
if_id_instr  out  ILEN  IF/ID instruction
pc  out  XLEN  current fetch PC
misaligned_trap  out  1  sticky; redirect target not 4-byte aligned

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on reset.
- Reset values:
  - pc = RESET_PC; state = IDLE; kill = 0; skid_valid = 0.
  - if_id_valid = 0; if_id_pc = 0; if_id_instr = NOP_INSTR; misaligned_trap = 0.
  - Reset mid-request aborts the request; any imem_valid seen in the reset cycle is ignored.
- Handshake:
  - imem_addr = pc.
  - imem_req = 1 only in FETCH.
  - While imem_req=1 and imem_valid=0, imem_addr stays stable.
  - One request is outstanding at most. Memory latency is 0 or more cycles (imem_valid may rise in the same cycle as imem_req).
- States:
  - IDLE: imem_req=0. Next state is FETCH. This gives one idle cycle after reset release.
  - FETCH, on imem_valid=1:
    - kill=1: discard the word, clear kill, stay in FETCH.
    - kill=0, stall=0: IF/ID <= {1, pc, imem_rdata}; pc <= pc+PC_STEP.
    - kill=0, stall=1: skid <= {pc, imem_rdata}; skid_valid=1; pc <= pc+PC_STEP; go to HOLD.
  - FETCH, on imem_valid=0: no change.
  - HOLD: imem_req=0. When stall=0: IF/ID <= skid, skid_valid=0, go to FETCH.
  - HALT: imem_req=0. if_id_valid forced to 0. Only reset exits.
- Stall without a response: IF/ID contents and valid are held unchanged.
- Redirect (priority over stall and response; below reset):
  - pc <= redirect_pc; if_id_valid <= 0; if_id_instr <= NOP_INSTR; skid_valid <= 0.
  - Next state is FETCH.
  - If in FETCH with imem_req=1 and imem_valid=0 this cycle, set kill=1.
  - Keep the old imem_addr until the killed response returns, then issue redirect_pc.
  - If imem_valid=1 in the redirect cycle, drop the word; kill stays 0.
  - redirect_pc[1:0] != 0: set misaligned_trap, go to HALT.
- Arithmetic: pc+PC_STEP is modulo 2^XLEN, so 64'hFFFF_FFFF_FFFF_FFFC + 4 = 0. No overflow flag.
- Bubble: whenever if_id_valid=0, if_id_instr = NOP_INSTR.

Decomposition:
- Shared package riscv_pkg:
  - XLEN, ILEN, NOP_INSTR.
  - fetch-state enum {IDLE, FETCH, HOLD, HALT}.
  - if_id_t struct {valid, pc, instr}, reused by the ID stage.
- One sub-module: if_id_reg. It holds the IF/ID register with load/hold/clear controls plus the skid entry.
- The FSM and the PC register stay in if_fetch_stage.

Test Plan:
- Reset release, imem_valid tied 1, rdata = 32'hAAAA0000+addr → IDLE for one cycle, then if_id_pc 0, 4, 8 on consecutive cycles with matching instr and valid=1.
- Stall raised for 3 cycles as the word for pc=8 returns → word captured in skid, imem_req=0 while held; after release if_id shows pc 8 and pc is 12, no word lost or duplicated.
- Redirect to 64'd40 while a 3-cycle-latency fetch at pc=16 is outstanding → imem_addr stays 16 until that response; the response is discarded, next request addr=40, next valid IF/ID pc=40, no instruction from 16 or 20.
- Redirect and stall asserted in the same cycle → pc=redirect_pc, if_id_valid=0, if_id_instr=32'h00000013.
- Redirect to 64'd30 (imm=-10<<1 case) → misaligned_trap=1, imem_req=0 and HALT held until reset.
- pc = 64'hFFFF_FFFF_FFFF_FFFC fetched → pc wraps to 0; reset asserted mid-wait → next visible state is IDLE with pc=RESET_PC.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions.
// Provides the datapath widths, the bubble instruction, the fetch-stage
// state encoding and the IF/ID pipeline record. The ID stage reuses the
// IF/ID record.
package riscv_pkg;

    localparam int XLEN = 64;
    localparam int ILEN = 32;
    localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        HALT  = 2'd3
    } fetch_state_t;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } if_id_t;

endpackage

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory request/response channel.
//   req   : fetch request, held until valid completes it
//   addr  : fetch address, stable while req=1 and valid=0
//   valid : response valid, completes the outstanding request
//   rdata : fetched instruction word
// master = fetch stage, slave = instruction memory.
interface if_fetch_stage_if;
    import riscv_pkg::*;

    logic            req;
    logic [XLEN-1:0] addr;
    logic            valid;
    logic [ILEN-1:0] rdata;

    modport master (output req, output addr, input valid, input rdata);
    modport slave  (input req, input addr, output valid, output rdata);
endinterface

// File: rtl/if_fetch_stage_if_id_reg.sv
// IF/ID pipeline register plus one skid entry.
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   load           : write in_pc/in_instr straight into IF/ID
//   skid_capture   : park in_pc/in_instr in the skid entry
//   skid_pop       : move the skid entry into IF/ID
//   flush          : make IF/ID a bubble and drop the skid entry
//   in_pc/in_instr : incoming fetched word and its PC
//   if_id          : IF/ID record (instr is NOP_INSTR whenever valid=0)
//   skid_valid     : skid entry holds a word
module if_id_reg
    import riscv_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic            skid_capture,
    input  logic            skid_pop,
    input  logic            flush,
    input  logic [XLEN-1:0] in_pc,
    input  logic [ILEN-1:0] in_instr,
    output if_id_t          if_id,
    output logic            skid_valid
);

    logic [XLEN-1:0] skid_pc;
    logic [ILEN-1:0] skid_instr;

    always_ff @(posedge clk) begin
        if (reset) begin
            if_id.valid <= 1'b0;
            if_id.pc    <= '0;
            if_id.instr <= NOP_INSTR;
            skid_pc     <= '0;
            skid_instr  <= NOP_INSTR;
            skid_valid  <= 1'b0;
        end else if (flush) begin
            // pc is left as-is; only valid/instr define a bubble
            if_id.valid <= 1'b0;
            if_id.instr <= NOP_INSTR;
            skid_valid  <= 1'b0;
        end else begin
            if (load) begin
                if_id.valid <= 1'b1;
                if_id.pc    <= in_pc;
                if_id.instr <= in_instr;
            end else if (skid_pop) begin
                if_id.valid <= 1'b1;
                if_id.pc    <= skid_pc;
                if_id.instr <= skid_instr;
                skid_valid  <= 1'b0;
            end
            if (skid_capture) begin
                skid_pc    <= in_pc;
                skid_instr <= in_instr;
                skid_valid <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC register, single-outstanding imem handshake,
// IF/ID load with one skid entry, branch redirect with in-flight kill.
//
// state | meaning
// IDLE  | one quiet cycle after reset, no request
// FETCH | request pc (or the killed address) and wait for the response
// HOLD  | decode stalled with a fetched word parked in the skid entry
// HALT  | misaligned redirect target seen; only reset leaves
//
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   redirect_valid/_pc  : taken branch from EX and its target
//   stall               : IF/ID must hold
//   imem                : instruction-memory channel (master side)
//   if_id_valid/_pc/_instr : IF/ID pipeline register
//   pc                  : current fetch PC
//   misaligned_trap     : sticky, redirect target not 4-byte aligned
module if_fetch_stage
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 64'd0,
    parameter int              PC_STEP  = 4
)(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     redirect_valid,
    input  logic [XLEN-1:0]          redirect_pc,
    input  logic                     stall,
    if_fetch_stage_if.master         imem,
    output logic                     if_id_valid,
    output logic [XLEN-1:0]          if_id_pc,
    output logic [ILEN-1:0]          if_id_instr,
    output logic [XLEN-1:0]          pc,
    output logic                     misaligned_trap
);

    fetch_state_t    state;
    logic            req_q;
    logic            kill;
    logic [XLEN-1:0] kill_addr;
    logic [XLEN-1:0] pc_next_seq;
    logic            redirect_take;
    logic            fetch_done;
    logic            load;
    logic            skid_capture;
    logic            skid_pop;
    logic            flush;
    logic            skid_valid;
    if_id_t          if_id;

    // While a killed response is outstanding the old address must stay on
    // the bus; pc already holds the redirect target.
    assign imem.req  = req_q;
    assign imem.addr = kill ? kill_addr : pc;

    assign pc_next_seq   = pc + XLEN'(PC_STEP);
    assign redirect_take = redirect_valid && (state != HALT);
    assign fetch_done    = (state == FETCH) && imem.valid && !kill && !redirect_take;

    assign load         = fetch_done && !stall;
    assign skid_capture = fetch_done && stall;
    assign skid_pop     = !redirect_take && (state == HOLD) && !stall && skid_valid;
    assign flush        = redirect_take || (state == HALT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            req_q           <= 1'b0;
            pc              <= RESET_PC;
            kill            <= 1'b0;
            kill_addr       <= '0;
            misaligned_trap <= 1'b0;
        end else if (redirect_take) begin
            pc <= redirect_pc;
            // A response arriving in this cycle is simply dropped; only a
            // still-pending request needs killing.
            kill <= (state == FETCH) && !imem.valid;
            if (!kill) begin
                kill_addr <= pc;
            end
            if (redirect_pc[1:0] != 2'b00) begin
                misaligned_trap <= 1'b1;
                state           <= HALT;
                req_q           <= 1'b0;
            end else begin
                state <= FETCH;
                req_q <= 1'b1;
            end
        end else begin
            case (state)
                IDLE: begin
                    state <= FETCH;
                    req_q <= 1'b1;
                end
                FETCH: begin
                    if (imem.valid) begin
                        if (kill) begin
                            kill <= 1'b0;
                        end else begin
                            pc <= pc_next_seq;
                            if (stall) begin
                                state <= HOLD;
                                req_q <= 1'b0;
                            end
                        end
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        state <= FETCH;
                        req_q <= 1'b1;
                    end
                end
                HALT: begin
                    req_q <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    req_q <= 1'b0;
                end
            endcase
        end
    end

    if_id_reg u_if_id_reg (
        .clk          (clk),
        .reset        (reset),
        .load         (load),
        .skid_capture (skid_capture),
        .skid_pop     (skid_pop),
        .flush        (flush),
        .in_pc        (pc),
        .in_instr     (imem.rdata),
        .if_id        (if_id),
        .skid_valid   (skid_valid)
    );

    assign if_id_valid = if_id.valid;
    assign if_id_pc    = if_id.pc;
    assign if_id_instr = if_id.instr;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: a per-cycle vector table followed by
// hand-written reset-mid-wait and misaligned-halt sequences.
module tb_if_fetch_stage;
    import riscv_pkg::*;

    localparam logic [ILEN-1:0] NOP = 32'h0000_0013;

    logic            clk = 1'b0;
    logic            reset;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            stall;
    logic            if_id_valid;
    logic [XLEN-1:0] if_id_pc;
    logic [ILEN-1:0] if_id_instr;
    logic [XLEN-1:0] pc;
    logic            misaligned_trap;

    int n_pass  = 0;
    int n_total = 0;

    if_fetch_stage_if mem ();

    // Memory returns a word derived from its address.
    assign mem.rdata = 32'hAAAA_0000 + 32'(mem.addr);

    if_fetch_stage dut (
        .clk             (clk),
        .reset           (reset),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .stall           (stall),
        .imem            (mem.master),
        .if_id_valid     (if_id_valid),
        .if_id_pc        (if_id_pc),
        .if_id_instr     (if_id_instr),
        .pc              (pc),
        .misaligned_trap (misaligned_trap)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic            rv;
        logic [XLEN-1:0] rpc;
        logic            st;
        logic            mv;
        logic            e_req;
        logic [XLEN-1:0] e_addr;
        logic            e_ifv;
        logic [XLEN-1:0] e_ifpc;
        logic [ILEN-1:0] e_ifinstr;
        logic [XLEN-1:0] e_pc;
        logic            e_trap;
    } vec_t;

    vec_t vecs [18];

    task automatic chk(input string name, input int idx, input logic [XLEN-1:0] act,
                       input logic [XLEN-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
    endtask

    task automatic set_in(input logic rv, input logic [XLEN-1:0] rpc, input logic st,
                          input logic mv);
        redirect_valid = rv;
        redirect_pc    = rpc;
        stall          = st;
        mem.valid      = mv;
    endtask

    // Called just after a negedge: drive, check current-cycle request, clock,
    // then check the registered results.
    task automatic run_vec(input int i, input vec_t v);
        set_in(v.rv, v.rpc, v.st, v.mv);
        #1;
        chk("req",  i, {63'd0, mem.req}, {63'd0, v.e_req});
        chk("addr", i, mem.addr, v.e_addr);
        @(posedge clk);
        #1;
        chk("if_valid", i, {63'd0, if_id_valid}, {63'd0, v.e_ifv});
        chk("if_pc",    i, if_id_pc, v.e_ifpc);
        chk("if_instr", i, {32'd0, if_id_instr}, {32'd0, v.e_ifinstr});
        chk("pc",       i, pc, v.e_pc);
        chk("trap",     i, {63'd0, misaligned_trap}, {63'd0, v.e_trap});
        @(negedge clk);
    endtask

    initial begin
        //             rv  rpc                     st  mv  req addr                    ifv ifpc                   ifinstr        pc                      trap
        vecs[0]  = '{1'b0, 64'd0,                1'b0,1'b1, 1'b0, 64'd0,               1'b0, 64'd0,               NOP,           64'd0,               1'b0};
        vecs[1]  = '{1'b0, 64'd0,                1'b0,1'b1, 1'b1, 64'd0,               1'b1, 64'd0,               32'hAAAA0000,  64'd4,               1'b0};
        vecs[2]  = '{1'b0, 64'd0,                1'b0,1'b1, 1'b1, 64'd4,               1'b1, 64'd4,               32'hAAAA0004,  64'd8,               1'b0};
        vecs[3]  = '{1'b0, 64'd0,                1'b1,1'b1, 1'b1, 64'd8,               1'b1, 64'd4,               32'hAAAA0004,  64'd12,              1'b0};
        vecs[4]  = '{1'b0, 64'd0,                1'b1,1'b1, 1'b0, 64'd12,              1'b1, 64'd4,               32'hAAAA0004,  64'd12,              1'b0};
        vecs[5]  = '{1'b0, 64'd0,                1'b1,1'b1, 1'b0, 64'd12,              1'b1, 64'd4,               32'hAAAA0004,  64'd12,              1'b0};
        vecs[6]  = '{1'b0, 64'd0,                1'b0,1'b1, 1'b0, 64'd12,              1'b1, 64'd8,               32'hAAAA0008,  64'd12,              1'b0};
        vecs[7]  = '{1'b0, 64'd0,                1'b0,1'b1, 1'b1, 64'd12,              1'b1, 64'd12,              32'hAAAA000C,  64'd16,              1'b0};
        vecs[8]  = '{1'b0, 64'd0,                1'b0,1'b0, 1'b1, 64'd16,              1'b1, 64'd12,              32'hAAAA000C,  64'd16,              1'b0};
        vecs[9]  = '{1'b1, 64'd40,               1'b0,1'b0, 1'b1, 64'd16,              1'b0, 64'd12,              NOP,           64'd40,              1'b0};
        vecs[10] = '{1'b0, 64'd0,                1'b0,1'b0, 1'b1, 64'd16,              1'b0, 64'd12,              NOP,           64'd40,              1'b0};
        vecs[11] = '{1'b0, 64'd0,                1'b0,1'b1, 1'b1, 64'd16,              1'b0, 64'd12,              NOP,           64'd40,              1'b0};
        vecs[12] = '{1'b0, 64'd0,                1'b0,1'b1, 1'b1, 64'd40,              1'b1, 64'd40,              32'hAAAA0028,  64'd44,              1'b0};
        vecs[13] = '{1'b1, 64'd100,              1'b1,1'b1, 1'b1, 64'd44,              1'b0, 64'd40,              NOP,           64'd100,             1'b0};
        vecs[14] = '{1'b0, 64'd0,                1'b0,1'b1, 1'b1, 64'd100,             1'b1, 64'd100,             32'hAAAA0064,  64'd104,             1'b0};
        vecs[15] = '{1'b1, 64'hFFFFFFFFFFFFFFFC, 1'b0,1'b1, 1'b1, 64'd104,             1'b0, 64'd100,             NOP,           64'hFFFFFFFFFFFFFFFC,1'b0};
        vecs[16] = '{1'b0, 64'd0,                1'b0,1'b1, 1'b1, 64'hFFFFFFFFFFFFFFFC,1'b1, 64'hFFFFFFFFFFFFFFFC,32'hAAA9FFFC,  64'd0,               1'b0};
        vecs[17] = '{1'b0, 64'd0,                1'b0,1'b1, 1'b1, 64'd0,               1'b1, 64'd0,               32'hAAAA0000,  64'd4,               1'b0};

        reset = 1'b1;
        set_in(1'b0, 64'd0, 1'b0, 1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Reset values, observed in the IDLE cycle.
        chk("rst_req",      0, {63'd0, mem.req}, 64'd0);
        chk("rst_pc",       0, pc, 64'd0);
        chk("rst_if_valid", 0, {63'd0, if_id_valid}, 64'd0);
        chk("rst_if_pc",    0, if_id_pc, 64'd0);
        chk("rst_if_instr", 0, {32'd0, if_id_instr}, {32'd0, NOP});
        chk("rst_trap",     0, {63'd0, misaligned_trap}, 64'd0);

        for (int i = 0; i < 18; i++) run_vec(i, vecs[i]);

        // Reset arriving while a fetch at pc=4 is pending; the response in
        // the reset cycle must be ignored.
        set_in(1'b0, 64'd0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk("wait_pc", 0, pc, 64'd4);
        chk("wait_addr", 0, mem.addr, 64'd4);
        @(negedge clk);
        reset = 1'b1;
        mem.valid = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_pc",    0, pc, 64'd0);
        chk("mid_rst_req",   0, {63'd0, mem.req}, 64'd0);
        chk("mid_rst_ifv",   0, {63'd0, if_id_valid}, 64'd0);
        chk("mid_rst_instr", 0, {32'd0, if_id_instr}, {32'd0, NOP});
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("post_rst_idle", 0, {63'd0, mem.req}, 64'd0);
        @(posedge clk);
        #1;
        chk("post_rst_fetch", 0, {63'd0, mem.req}, 64'd1);
        chk("post_rst_addr",  0, mem.addr, 64'd0);
        chk("post_rst_ifv",   0, {63'd0, if_id_valid}, 64'd0);
        @(negedge clk);

        // Fetch pc=0, then a misaligned redirect to 30 halts the stage.
        @(posedge clk);
        #1;
        chk("pre_halt_pc", 0, pc, 64'd4);
        @(negedge clk);
        set_in(1'b1, 64'd30, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        chk("halt_trap", 0, {63'd0, misaligned_trap}, 64'd1);
        chk("halt_pc",   0, pc, 64'd30);
        chk("halt_req",  0, {63'd0, mem.req}, 64'd0);
        chk("halt_ifv",  0, {63'd0, if_id_valid}, 64'd0);
        @(negedge clk);
        // Further aligned redirects must not leave HALT.
        set_in(1'b1, 64'd8, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            chk("halt_hold_req",  k, {63'd0, mem.req}, 64'd0);
            chk("halt_hold_trap", k, {63'd0, misaligned_trap}, 64'd1);
            chk("halt_hold_pc",   k, pc, 64'd30);
            chk("halt_hold_ifv",  k, {63'd0, if_id_valid}, 64'd0);
        end
        @(negedge clk);
        set_in(1'b0, 64'd0, 1'b0, 1'b1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("unhalt_trap", 0, {63'd0, misaligned_trap}, 64'd0);
        chk("unhalt_pc",   0, pc, 64'd0);
        @(negedge clk);
        reset = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
